// File: rtl/dcache_direct_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_direct_if
// Description : CPU-side and memory-side bundle for the direct-mapped D-cache.
// Revision    : 1.0 - initial release
// ============================================================================
interface dcache_direct_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      cpu_re;
    logic                      cpu_we;
    logic [2:0]                cpu_funct3;
    logic [ADDR_WIDTH-1:0]     cpu_addr;
    logic [DATA_WIDTH-1:0]     cpu_wdata;
    logic [DATA_WIDTH-1:0]     cpu_rdata;
    logic                      stall;
    logic                      mem_req;
    logic                      mem_we;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [DATA_WIDTH/8-1:0]   mem_wstrb;
    logic [DATA_WIDTH-1:0]     mem_rdata;
    logic                      mem_ack;

    modport slave (
        input  cpu_re, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
        output cpu_rdata, stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ack
    );

    modport master (
        output cpu_re, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
        input  cpu_rdata, stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ack
    );
endinterface
`default_nettype wire

// File: rtl/dcache_direct.sv
`default_nettype none
// ============================================================================
// Module      : dcache_direct
// Description : Direct-mapped, write-through, no-write-allocate RV32I D-cache.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_direct #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 64
) (
    input  wire logic      clk,
    input  wire logic      rst,
    dcache_direct_if.slave bus
);
    localparam int c_IDX_W = $clog2(SETS);
    localparam int c_TAG_W = ADDR_WIDTH - 2 - c_IDX_W;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_REFILL = 2'd1;
    localparam logic [1:0] c_WRITE  = 2'd2;

    logic [1:0]            r_state;
    logic [SETS-1:0]       r_valid;
    logic [DATA_WIDTH-1:0] r_data   [SETS];
    logic [c_TAG_W-1:0]    r_tagRam [SETS];
    logic [c_IDX_W-1:0]    r_idx;
    logic [c_TAG_W-1:0]    r_tag;
    logic                  r_memReq;
    logic                  r_memWe;
    logic [DATA_WIDTH-1:0] r_memWdata;
    logic [3:0]            r_memWstrb;

    logic [1:0]            w_off;
    logic [c_IDX_W-1:0]    w_idx;
    logic [c_TAG_W-1:0]    w_tag;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_hit;
    logic                  w_lineHit;
    logic                  w_idle;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_loadVal;
    logic [3:0]            w_strb;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_merged;

    assign w_off     = bus.cpu_addr[1:0];
    assign w_idx     = bus.cpu_addr[c_IDX_W+1:2];
    assign w_tag     = bus.cpu_addr[ADDR_WIDTH-1:c_IDX_W+2];
    assign w_word    = r_data[w_idx];
    assign w_hit     = r_valid[w_idx] && (r_tagRam[w_idx] == w_tag);
    assign w_lineHit = r_valid[r_idx] && (r_tagRam[r_idx] == r_tag);
    assign w_idle    = (r_state == c_IDLE);
    assign w_byte    = w_word[{w_off, 3'b000} +: 8];
    assign w_half    = w_word[{w_off[1], 4'b0000} +: 16];

    always_comb begin
        w_loadVal = w_word;
        case (bus.cpu_funct3)
            3'b000:  w_loadVal = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            3'b001:  w_loadVal = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            3'b100:  w_loadVal = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            3'b101:  w_loadVal = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: w_loadVal = w_word;
        endcase
    end

    // Misaligned halves/words simply drop the low offset bits.
    always_comb begin
        w_strb  = 4'hF;
        w_wdata = bus.cpu_wdata;
        case (bus.cpu_funct3[1:0])
            2'b00: begin
                w_strb  = 4'b0001 << w_off;
                w_wdata = {4{bus.cpu_wdata[7:0]}};
            end
            2'b01: begin
                w_strb  = 4'b0011 << {w_off[1], 1'b0};
                w_wdata = {2{bus.cpu_wdata[15:0]}};
            end
            default: begin
                w_strb  = 4'hF;
                w_wdata = bus.cpu_wdata;
            end
        endcase
    end

    always_comb begin
        w_merged = r_data[r_idx];
        for (int i = 0; i < 4; i++) begin
            if (r_memWstrb[i]) begin
                w_merged[8*i +: 8] = r_memWdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_IDLE;
            r_valid    <= '0;
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_idx      <= '0;
            r_tag      <= '0;
            r_memWdata <= '0;
            r_memWstrb <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.cpu_we) begin
                        r_idx      <= w_idx;
                        r_tag      <= w_tag;
                        r_memWdata <= w_wdata;
                        r_memWstrb <= w_strb;
                        r_memReq   <= 1'b1;
                        r_memWe    <= 1'b1;
                        r_state    <= c_WRITE;
                    end else if (bus.cpu_re && !w_hit) begin
                        r_idx      <= w_idx;
                        r_tag      <= w_tag;
                        r_memWdata <= '0;
                        r_memWstrb <= '0;
                        r_memReq   <= 1'b1;
                        r_memWe    <= 1'b0;
                        r_state    <= c_REFILL;
                    end
                end
                c_REFILL: begin
                    if (bus.mem_ack) begin
                        r_valid[r_idx] <= 1'b1;
                        r_memReq       <= 1'b0;
                        r_state        <= c_IDLE;
                    end
                end
                c_WRITE: begin
                    if (bus.mem_ack) begin
                        r_memReq <= 1'b0;
                        r_state  <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Arrays carry no reset; gating on rst drops an ack that coincides with reset.
    always_ff @(posedge clk) begin
        if (rst && bus.mem_ack) begin
            if (r_state == c_REFILL) begin
                r_data[r_idx]   <= bus.mem_rdata;
                r_tagRam[r_idx] <= r_tag;
            end else if ((r_state == c_WRITE) && w_lineHit) begin
                r_data[r_idx]   <= w_merged;
            end
        end
    end

    assign bus.mem_req   = r_memReq;
    assign bus.mem_we    = r_memWe;
    assign bus.mem_addr  = {r_tag, r_idx, 2'b00};
    assign bus.mem_wdata = r_memWdata;
    assign bus.mem_wstrb = r_memWstrb;

    assign bus.stall = (w_idle && (bus.cpu_we || (bus.cpu_re && !w_hit)))
                     || (r_state == c_REFILL)
                     || ((r_state == c_WRITE) && !bus.mem_ack);

    assign bus.cpu_rdata = (w_idle && bus.cpu_re && w_hit) ? w_loadVal : '0;
endmodule
`default_nettype wire

// File: tb/tb_dcache_direct.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_direct
// Description : Directed scoreboard bench for dcache_direct with a latency-3 memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_direct;
    localparam int c_SETS = 64;
    localparam int c_LAT  = 3;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_direct_if bus ();

    dcache_direct #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .SETS       (c_SETS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          npass  = 0;
    int          nfail  = 0;
    int          ntotal = 0;
    logic [31:0] memModel [int];
    logic [31:0] qRd [$];
    wr_t         qWr [$];
    bit          respEnable;
    bit          strayAck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Memory: acks in the c_LAT-th cycle mem_req is seen high.
    initial begin : responder
        int  cnt;
        wr_t e;
        logic [31:0] w;
        cnt = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
            end else if (strayAck) begin
                strayAck      = 1'b0;
                bus.mem_rdata = 32'hBAD0BAD0;
                bus.mem_ack   = 1'b1;
            end else if (!respEnable || !bus.mem_req) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt == c_LAT) begin
                    cnt = 0;
                    if (bus.mem_we) begin
                        check("wr_pending", {31'b0, qWr.size() != 0}, 32'd1);
                        if (qWr.size() != 0) begin
                            e = qWr.pop_front();
                            check("wr_addr", bus.mem_addr, e.addr);
                            check("wr_wdata", bus.mem_wdata, e.wdata);
                            check("wr_wstrb", {28'b0, bus.mem_wstrb}, {28'b0, e.wstrb});
                            w = memModel.exists(int'(e.addr)) ? memModel[int'(e.addr)] : 32'h0;
                            for (int i = 0; i < 4; i++) begin
                                if (e.wstrb[i]) w[8*i +: 8] = e.wdata[8*i +: 8];
                            end
                            memModel[int'(e.addr)] = w;
                        end
                    end else begin
                        check("rd_wstrb", {28'b0, bus.mem_wstrb}, 32'h0);
                        bus.mem_rdata = memModel.exists(int'(bus.mem_addr)) ?
                                        memModel[int'(bus.mem_addr)] : 32'h0;
                    end
                    bus.mem_ack = 1'b1;
                end
            end
        end
    end

    task automatic doLoad(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] exp, input int expStall);
        int stalls;
        @(negedge clk);
        bus.cpu_re     = 1'b1;
        bus.cpu_we     = 1'b0;
        bus.cpu_funct3 = f3;
        bus.cpu_addr   = addr;
        qRd.push_back(exp);
        #1;
        stalls = 0;
        while (bus.stall && stalls < 50) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        check({tag, "_stall"}, 32'(stalls), 32'(expStall));
        check(tag, bus.cpu_rdata, qRd.pop_front());
        check({tag, "_req"}, {31'b0, bus.mem_req}, 32'h0);
        @(negedge clk);
        bus.cpu_re = 1'b0;
    endtask

    task automatic doStore(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] wdata, input logic [31:0] expWdata,
                           input logic [3:0] expStrb);
        int stalls;
        @(negedge clk);
        bus.cpu_we     = 1'b1;
        bus.cpu_re     = 1'b0;
        bus.cpu_funct3 = f3;
        bus.cpu_addr   = addr;
        bus.cpu_wdata  = wdata;
        qWr.push_back('{addr: {addr[31:2], 2'b00}, wdata: expWdata, wstrb: expStrb});
        #1;
        stalls = 0;
        while (bus.stall && stalls < 50) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        check({tag, "_stall"}, 32'(stalls), 32'(c_LAT));
        @(negedge clk);
        bus.cpu_we = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation timeout");
    end

    initial begin : stimulus
        rst            = 1'b0;
        respEnable     = 1'b1;
        strayAck       = 1'b0;
        bus.cpu_re     = 1'b0;
        bus.cpu_we     = 1'b0;
        bus.cpu_funct3 = 3'b010;
        bus.cpu_addr   = 32'h0;
        bus.cpu_wdata  = 32'h0;
        memModel[32'h100] = 32'hDEADBEEF;
        memModel[32'h200] = 32'h0BADF00D;

        repeat (2) @(negedge clk);
        #1;
        check("rst_req",   {31'b0, bus.mem_req}, 32'h0);
        check("rst_we",    {31'b0, bus.mem_we}, 32'h0);
        check("rst_addr",  bus.mem_addr, 32'h0);
        check("rst_wdata", bus.mem_wdata, 32'h0);
        check("rst_wstrb", {28'b0, bus.mem_wstrb}, 32'h0);
        check("rst_stall", {31'b0, bus.stall}, 32'h0);
        check("rst_rdata", bus.cpu_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Cold miss, then same-line extractions
        doLoad("t1_lw",  32'h100, 3'b010, 32'hDEADBEEF, 4);
        doLoad("t2_lb",  32'h103, 3'b000, 32'hFFFFFFDE, 0);
        doLoad("t2_lbu", 32'h103, 3'b100, 32'h000000DE, 0);
        doLoad("t2_lh",  32'h102, 3'b001, 32'hFFFFDEAD, 0);
        doLoad("t2_lhu", 32'h100, 3'b101, 32'h0000BEEF, 0);

        // Store hits merge into the line
        doStore("t3_sb", 32'h101, 3'b000, 32'h00000055, 32'h55555555, 4'b0010);
        doLoad("t3_lw",  32'h100, 3'b010, 32'hDEAD55EF, 0);
        doStore("t3_sh", 32'h102, 3'b001, 32'hFFFF1234, 32'h12341234, 4'b1100);
        doLoad("t3_lw2", 32'h100, 3'b010, 32'h123455EF, 0);

        // Store miss: no allocate, resident line untouched
        doStore("t4_sw", 32'h200, 3'b010, 32'hCAFEF00D, 32'hCAFEF00D, 4'b1111);
        doLoad("t4_keep", 32'h100, 3'b010, 32'h123455EF, 0);
        doLoad("t4_lw",   32'h200, 3'b010, 32'hCAFEF00D, 4);

        // Conflict eviction on the same index
        doLoad("t5_a",  32'h100, 3'b010, 32'h123455EF, 4);
        doLoad("t5_b",  32'h100 + 4 * c_SETS, 3'b010, 32'hCAFEF00D, 4);
        doLoad("t5_a2", 32'h100, 3'b010, 32'h123455EF, 4);

        // Reset during a refill wait
        respEnable = 1'b0;
        @(negedge clk);
        bus.cpu_re     = 1'b1;
        bus.cpu_funct3 = 3'b010;
        bus.cpu_addr   = 32'h140;
        #1;
        check("t6_stall_req", {31'b0, bus.stall}, 32'h1);
        @(negedge clk);
        #1;
        check("t6_req",  {31'b0, bus.mem_req}, 32'h1);
        check("t6_addr", bus.mem_addr, 32'h140);
        @(negedge clk);
        rst        = 1'b0;
        bus.cpu_re = 1'b0;
        @(negedge clk);
        #1;
        check("t6_req_drop", {31'b0, bus.mem_req}, 32'h0);
        check("t6_idle",     {31'b0, bus.stall}, 32'h0);
        check("t6_addr_rst", bus.mem_addr, 32'h0);
        rst      = 1'b1;
        strayAck = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("t6_stray_req",   {31'b0, bus.mem_req}, 32'h0);
        check("t6_stray_stall", {31'b0, bus.stall}, 32'h0);
        respEnable = 1'b1;
        doLoad("t6_lw",  32'h100, 3'b010, 32'h123455EF, 4);
        doLoad("t6_f3",  32'h100, 3'b011, 32'h123455EF, 0);
        doLoad("t6_lb1", 32'h101, 3'b000, 32'h00000055, 0);

        @(negedge clk);
        #1;
        check("idle_rdata", bus.cpu_rdata, 32'h0);
        check("sb_rd_empty", 32'(qRd.size()), 32'h0);
        check("sb_wr_empty", 32'(qWr.size()), 32'h0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
`default_nettype wire
